banked_mem: RTL and testbench
=============================

BANKED_MEM -- requirements
Module: banked_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDRESS_WIDTH, default 8: word address width; total depth SHALL be 2**ADDRESS_WIDTH words.
REQ-003 Parameter NUM_BANKS, default 4: bank count; SHALL be a power of two, at least 2, at most 2**ADDRESS_WIDTH.
REQ-004 Derived constants: BE_WIDTH = DATA_WIDTH/8; BANK_BITS = log2(NUM_BANKS).
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 a_req  input  1  port A request valid.
REQ-008 a_we  input  1  port A write (1) or read (0).
REQ-009 a_addr  input  ADDRESS_WIDTH  port A word address.
REQ-010 a_wdata  input  DATA_WIDTH  port A write data.
REQ-011 a_be  input  BE_WIDTH  port A byte-lane write enables.
REQ-012 a_ready  output  1  port A request accepted this cycle.
REQ-013 a_rvalid  output  1  port A read data valid.
REQ-014 a_rdata  output  DATA_WIDTH  port A read data.
REQ-015 b_req, b_we, b_addr, b_wdata, b_be, b_ready, b_rvalid, b_rdata: port B, identical to REQ-007..014.

Function
REQ-016 Bank index SHALL be addr[BANK_BITS-1:0]; row SHALL be addr[ADDRESS_WIDTH-1:BANK_BITS].
REQ-017 Port behaviour: each bank serves at most one access per cycle; a request is accepted when req && ready at a rising edge.
REQ-018 Ready timing: x_ready SHALL be combinational from the current requests and the priority pointer; it SHALL be 0 whenever x_req=0 or rst=1.
REQ-019 Different banks: requests to different banks SHALL both be accepted in the same cycle.
REQ-020 Same-bank conflict: exactly one port SHALL be accepted, chosen by a round-robin pointer; the winning port then loses priority to the other port.
REQ-021 Pointer update: the pointer SHALL change only on a conflict cycle.
REQ-022 Stalled requests: a port that is not accepted SHALL hold req, we, addr, wdata and be stable until accepted; the block need not tolerate violations.
REQ-023 Read latency: an accepted read SHALL return x_rdata = mem[addr] with x_rvalid=1 for exactly one cycle, on the cycle after acceptance.
REQ-024 Back-to-back reads: these SHALL yield back-to-back rvalid pulses with no gaps.
REQ-025 Read data hold: x_rdata SHALL hold its last value while x_rvalid=0.
REQ-026 Accepted write: lane i (bits 8i+7:8i) SHALL be written iff be[i]=1; other lanes retain their contents.
REQ-027 Write completion: a write SHALL produce no rvalid.
REQ-028 Write with be=0: this SHALL be accepted and consume the bank slot, but change nothing.
REQ-029 Read after write: a read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-030 Same-cycle access: same-cycle accesses to one address are impossible, because same-bank requests are serialised per REQ-020.
REQ-031 Address range: every address is in range; no error signalling is provided.

Reset
REQ-032 Outputs under reset: while rst=1, a_rvalid and b_rvalid SHALL be 0 and a_rdata and b_rdata SHALL be 0.
REQ-033 Pointer under reset: the priority pointer SHALL reset to favour port A.
REQ-034 Memory contents: these SHALL NOT be reset.
REQ-035 Reset mid-operation: a read accepted in the cycle before rst asserts SHALL produce no rvalid.
REQ-036 Writes under reset: no write SHALL occur while rst=1.

Structure
REQ-037 Shared package: a shared package SHALL hold the port-select enum (PORT_A, PORT_B) and a bank-index helper function.
REQ-038 Sub-module: one sub-module, mem_bank, SHALL be instantiated NUM_BANKS times; it is a single-port synchronous RAM of depth 2**(ADDRESS_WIDTH-BANK_BITS) with byte enables and 1-cycle read latency.
REQ-039 Top level: arbitration, crossbar muxing and rvalid tracking SHALL reside in banked_mem.

Verification (defaults: DATA_WIDTH=32, NUM_BANKS=4)
REQ-040 Different banks: A writes 0xDEADBEEF to address 0x04 and B writes 0x12345678 to 0x05 in the same cycle -> both ready=1; later reads return those values with rvalid one cycle after acceptance.
REQ-041 Conflict sequence: A and B both read bank 0 (addresses 0x00 and 0x08) continuously for 4 cycles after reset -> grants A, B, A, B; each rvalid follows its grant by 1 cycle.
REQ-042 Byte enables: write 0xAABBCCDD to 0x10 with be=1111, then 0x11223344 with be=0101 -> read returns 0xAA22CC44.
REQ-043 Read after write: write 0x5 to 0x20, read 0x20 the next cycle -> rdata=0x5 and rvalid=1 two cycles after the write.
REQ-044 Reset mid-read: read accepted, rst asserted the next cycle -> rvalid stays 0, rdata=0; after release the pointer favours A.
REQ-045 be=0 write: write with be=0000 to 0x30 holding 0x77 -> read returns 0x77; ready=1 on the write cycle.

Source files
------------

// File: rtl/banked_mem_pkg.sv
// -----------------------------------------------------------------------------
// banked_mem_pkg
// Shared definitions for the banked dual-port memory.
//   port_sel_e  : identifies port A or port B (used for the round-robin pointer)
//   bank_index  : extracts the bank number from a word address (low-order bits)
// -----------------------------------------------------------------------------
package banked_mem_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // Words are interleaved across banks on the low-order address bits, so
    // consecutive addresses land in different banks.
    function automatic int unsigned bank_index(input logic [31:0] addr,
                                               input int unsigned bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_bank.sv
// -----------------------------------------------------------------------------
// mem_bank
// Single-port synchronous RAM with byte-lane write enables and a one-cycle
// registered read. Contents are never reset.
// Ports:
//   clk      : clock
//   i_en     : access enable (one access per cycle)
//   i_we     : 1 = write, 0 = read
//   i_row    : row address within the bank
//   i_wdata  : write data
//   i_be     : byte-lane write enables
//   o_rdata  : read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module mem_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_WIDTH  = 6,
    localparam int BE_WIDTH  = DATA_WIDTH / 8,
    localparam int DEPTH     = 2 ** ROW_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ROW_WIDTH-1:0]  i_row,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_WIDTH-1:0]   i_be,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array: byte-masked writes and registered reads.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (i_be[i]) begin
                    r_mem[i_row][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_en && !i_we) begin
            r_rdata <= r_mem[i_row];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_mem.sv
// -----------------------------------------------------------------------------
// banked_mem
// Dual-port memory built from NUM_BANKS single-port banks. Requests to
// different banks proceed in parallel; same-bank requests are serialised by a
// round-robin pointer that flips only on conflict cycles.
// Ports (x = a or b):
//   clk, rst   : clock, asynchronous active-high reset
//   x_req      : request valid
//   x_we       : 1 = write, 0 = read
//   x_addr     : word address (bank = low bits, row = high bits)
//   x_wdata    : write data
//   x_be       : byte-lane write enables
//   x_ready    : combinational accept for this cycle
//   x_rvalid   : one-cycle read-data-valid pulse, cycle after acceptance
//   x_rdata    : read data; holds last returned value while x_rvalid = 0
// -----------------------------------------------------------------------------
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int NUM_BANKS     = 4,
    localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    input  logic [BE_WIDTH-1:0]      a_be,
    output logic                     a_ready,
    output logic                     a_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    input  logic [BE_WIDTH-1:0]      b_be,
    output logic                     b_ready,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    b_rdata
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    // With one word per bank there are no row bits; keep a 1-bit row tied low.
    localparam int ROW_WIDTH = (ADDRESS_WIDTH > BANK_BITS) ? (ADDRESS_WIDTH - BANK_BITS) : 1;

    logic [BANK_BITS-1:0]  w_a_bank;
    logic [BANK_BITS-1:0]  w_b_bank;
    logic [ROW_WIDTH-1:0]  w_a_row;
    logic [ROW_WIDTH-1:0]  w_b_row;
    logic                  w_conflict;
    logic                  w_a_ready;
    logic                  w_b_ready;
    port_sel_e             r_ptr;

    logic                  w_bank_en    [NUM_BANKS];
    logic                  w_bank_we    [NUM_BANKS];
    logic [ROW_WIDTH-1:0]  w_bank_row   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_wdata [NUM_BANKS];
    logic [BE_WIDTH-1:0]   w_bank_be    [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

    logic                  r_a_rvalid;
    logic                  r_b_rvalid;
    logic [BANK_BITS-1:0]  r_a_bank;
    logic [BANK_BITS-1:0]  r_b_bank;
    logic [DATA_WIDTH-1:0] r_a_hold;
    logic [DATA_WIDTH-1:0] r_b_hold;

    assign w_a_bank = BANK_BITS'(bank_index(32'(a_addr), BANK_BITS));
    assign w_b_bank = BANK_BITS'(bank_index(32'(b_addr), BANK_BITS));
    assign w_a_row  = ROW_WIDTH'(a_addr >> BANK_BITS);
    assign w_b_row  = ROW_WIDTH'(b_addr >> BANK_BITS);

    // Arbitration: both ports pass unless they collide on one bank, in which
    // case only the port favoured by the pointer is accepted.
    always_comb begin
        w_conflict = a_req && b_req && (w_a_bank == w_b_bank);
        w_a_ready  = 1'b0;
        w_b_ready  = 1'b0;
        if (rst) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b0;
        end else if (w_conflict) begin
            w_a_ready = (r_ptr == PORT_A);
            w_b_ready = (r_ptr == PORT_B);
        end else begin
            w_a_ready = a_req;
            w_b_ready = b_req;
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;

    // Round-robin pointer: the conflict winner hands priority to the other port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PORT_A;
        end else if (w_conflict) begin
            r_ptr <= (r_ptr == PORT_A) ? PORT_B : PORT_A;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Crossbar: route each accepted request to its bank. Accepted ports never
    // share a bank, so at most one branch matches per bank.
    always_comb begin
        for (int g = 0; g < NUM_BANKS; g++) begin
            w_bank_en[g]    = 1'b0;
            w_bank_we[g]    = 1'b0;
            w_bank_row[g]   = '0;
            w_bank_wdata[g] = '0;
            w_bank_be[g]    = '0;
            if (w_a_ready && (w_a_bank == BANK_BITS'(g))) begin
                w_bank_en[g]    = 1'b1;
                w_bank_we[g]    = a_we;
                w_bank_row[g]   = w_a_row;
                w_bank_wdata[g] = a_wdata;
                w_bank_be[g]    = a_be;
            end else if (w_b_ready && (w_b_bank == BANK_BITS'(g))) begin
                w_bank_en[g]    = 1'b1;
                w_bank_we[g]    = b_we;
                w_bank_row[g]   = w_b_row;
                w_bank_wdata[g] = b_wdata;
                w_bank_be[g]    = b_be;
            end else begin
                w_bank_en[g]    = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROW_WIDTH  (ROW_WIDTH)
        ) u_bank (
            .clk     (clk),
            .i_en    (w_bank_en[g]),
            .i_we    (w_bank_we[g]),
            .i_row   (w_bank_row[g]),
            .i_wdata (w_bank_wdata[g]),
            .i_be    (w_bank_be[g]),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // Read tracking: remember which bank each port read from so its data can
    // be steered back next cycle, and latch it so rdata holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_bank   <= '0;
            r_b_bank   <= '0;
            r_a_hold   <= '0;
            r_b_hold   <= '0;
        end else begin
            r_a_rvalid <= w_a_ready && !a_we;
            r_b_rvalid <= w_b_ready && !b_we;
            if (w_a_ready && !a_we) begin
                r_a_bank <= w_a_bank;
            end
            if (w_b_ready && !b_we) begin
                r_b_bank <= w_b_bank;
            end
            if (r_a_rvalid) begin
                r_a_hold <= w_bank_rdata[r_a_bank];
            end
            if (r_b_rvalid) begin
                r_b_hold <= w_bank_rdata[r_b_bank];
            end
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rvalid ? w_bank_rdata[r_a_bank] : r_a_hold;
    assign b_rdata  = r_b_rvalid ? w_bank_rdata[r_b_bank] : r_b_hold;

endmodule

// File: tb/tb_banked_mem.sv
// -----------------------------------------------------------------------------
// tb_banked_mem
// Self-checking bench for banked_mem: directed scenarios followed by random
// traffic, all compared against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_banked_mem;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NB  = 4;
    localparam int BEW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [BEW-1:0] a_be, b_be;
    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [DW-1:0] model_mem [2**AW];
    bit            fav_b;
    bit            exp_a_rvalid, exp_b_rvalid;
    logic [DW-1:0] exp_a_rdata, exp_b_rdata;
    bit            acc_a, acc_b;

    always #5 clk = ~clk;

    banked_mem #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BEW; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic set_a(input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BEW-1:0] be);
        a_req = req; a_we = we; a_addr = addr; a_wdata = data; a_be = be;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BEW-1:0] be);
        b_req = req; b_we = we; b_addr = addr; b_wdata = data; b_be = be;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    // One clock cycle: check current outputs at the falling edge, then advance
    // the model across the rising edge. Inputs are set by the caller beforehand.
    task automatic tick();
        bit            conflict, ea, eb, na, nb;
        logic [DW-1:0] ra, rb;
        @(negedge clk);
        if (rst) begin
            fav_b = 1'b0;
            exp_a_rvalid = 1'b0; exp_b_rvalid = 1'b0;
            exp_a_rdata = '0;    exp_b_rdata = '0;
        end
        conflict = a_req && b_req && ((a_addr % NB) == (b_addr % NB));
        ea = !rst && a_req && (!conflict || !fav_b);
        eb = !rst && b_req && (!conflict || fav_b);
        check_val("a_ready",  DW'(a_ready),  DW'(ea));
        check_val("b_ready",  DW'(b_ready),  DW'(eb));
        check_val("a_rvalid", DW'(a_rvalid), DW'(exp_a_rvalid));
        check_val("b_rvalid", DW'(b_rvalid), DW'(exp_b_rvalid));
        check_val("a_rdata",  a_rdata, exp_a_rdata);
        check_val("b_rdata",  b_rdata, exp_b_rdata);
        acc_a = ea; acc_b = eb;
        ra = model_mem[a_addr];
        rb = model_mem[b_addr];
        if (ea && a_we) model_mem[a_addr] = merge(model_mem[a_addr], a_wdata, a_be);
        if (eb && b_we) model_mem[b_addr] = merge(model_mem[b_addr], b_wdata, b_be);
        if (!rst && conflict) fav_b = !fav_b;
        na = ea && !a_we;
        nb = eb && !b_we;
        @(posedge clk);
        #1;
        exp_a_rvalid = na;
        exp_b_rvalid = nb;
        if (na) exp_a_rdata = ra;
        if (nb) exp_b_rdata = rb;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit pa, pb;
        rst = 1'b1;
        idle();
        #1;
        do_reset();

        // Fill every word so later reads have defined contents (even/odd
        // addresses always sit in different banks).
        for (int k = 0; k < 2**(AW-1); k++) begin
            set_a(1'b1, 1'b1, AW'(2*k),     DW'($urandom), 4'hF);
            set_b(1'b1, 1'b1, AW'(2*k + 1), DW'($urandom), 4'hF);
            tick();
        end

        // Parallel writes to different banks, then cross reads
        set_a(1'b1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
        set_b(1'b1, 1'b1, 8'h05, 32'h12345678, 4'hF);
        tick();
        set_a(1'b1, 1'b0, 8'h05, '0, '0);
        set_b(1'b1, 1'b0, 8'h04, '0, '0);
        tick();
        check_val("diff_bank_a", a_rdata, 32'h12345678);
        check_val("diff_bank_b", b_rdata, 32'hDEADBEEF);
        idle();
        tick();

        // Continuous same-bank reads after reset alternate A, B, A, B
        do_reset();
        set_a(1'b1, 1'b0, 8'h00, '0, '0);
        set_b(1'b1, 1'b0, 8'h08, '0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rr_grant_a", DW'(acc_a), DW'((i % 2) == 0));
        end
        idle();
        tick();

        // Byte-lane merge
        set_a(1'b1, 1'b1, 8'h10, 32'hAABBCCDD, 4'b1111);
        tick();
        set_a(1'b1, 1'b1, 8'h10, 32'h11223344, 4'b0101);
        tick();
        set_a(1'b1, 1'b0, 8'h10, '0, '0);
        tick();
        check_val("be_merge", a_rdata, 32'hAA22CC44);
        idle();
        tick();

        // Read directly after write
        set_a(1'b1, 1'b1, 8'h20, 32'h5, 4'hF);
        tick();
        set_a(1'b1, 1'b0, 8'h20, '0, '0);
        tick();
        check_val("raw_rvalid", DW'(a_rvalid), 32'd1);
        check_val("raw_rdata", a_rdata, 32'h5);
        idle();
        tick();

        // Reset landing on the cycle after an accepted read
        set_a(1'b1, 1'b0, 8'h40, '0, '0);
        tick();
        rst = 1'b1;
        #1;
        check_val("rst_rvalid", DW'(a_rvalid), 32'd0);
        check_val("rst_rdata", a_rdata, 32'd0);
        tick();
        rst = 1'b0;
        set_a(1'b1, 1'b0, 8'h00, '0, '0);
        set_b(1'b1, 1'b0, 8'h04, '0, '0);
        tick();
        check_val("ptr_after_rst", DW'(acc_a), 32'd1);
        set_a(1'b0, 1'b0, '0, '0, '0);
        tick();
        idle();
        tick();

        // Write with no lanes enabled leaves the word untouched
        set_a(1'b1, 1'b1, 8'h30, 32'h77, 4'hF);
        tick();
        set_a(1'b1, 1'b1, 8'h30, 32'hFFFF_FFFF, 4'b0000);
        tick();
        check_val("be0_ready", DW'(acc_a), 32'd1);
        set_a(1'b1, 1'b0, 8'h30, '0, '0);
        tick();
        check_val("be0_rdata", a_rdata, 32'h77);
        idle();
        tick();

        // Random traffic; a stalled port holds its request until accepted
        pa = 1'b0;
        pb = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!pa) begin
                set_a($urandom_range(3) != 0, 1'($urandom_range(1)),
                      ($urandom_range(1) != 0) ? AW'($urandom_range(15)) : AW'($urandom),
                      DW'($urandom), BEW'($urandom));
            end
            if (!pb) begin
                set_b($urandom_range(3) != 0, 1'($urandom_range(1)),
                      ($urandom_range(1) != 0) ? AW'($urandom_range(15)) : AW'($urandom),
                      DW'($urandom), BEW'($urandom));
            end
            tick();
            pa = a_req && !acc_a;
            pb = b_req && !acc_b;
        end
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
